sprite_loader: RTL and testbench

Writer side of the 64×64 sprite pixel memory that the sprite draw stages read through their 12-bit `{y[5:0], x[5:0]}` pixel address.
- Takes a byte stream from the UART receiver.
- Frames it with a sync byte and packs byte pairs into 12-bit RGB pixels.
- Writes the pixels sequentially into the sprite RAM write port, under a grant from the memory arbiter.
- Reports busy, completion and error status to the game control logic.

---
 rtl/sprite_loader.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
`default_nettype none
// ============================================================================
// sprite_loader - UART byte stream to 64x64 sprite RAM writer (Rev 1.0)
// Optional trailing XOR checksum byte: define SPRITE_LOADER_CHECKSUM_EN
// ============================================================================
module sprite_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         PIXELS         = 4096,
    parameter int         TIMEOUT_CYCLES = 600000
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        wr_grant,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]       LAST_PIX   = 12'(PIXELS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK        = 3'd5;
    localparam logic [2:0] S_AFTER_LAST = S_CHK;
`else
    localparam logic [2:0] S_AFTER_LAST = S_END;
`endif

    logic [2:0]        state_q, state_d;
    logic [11:0]       pix_q, pix_d;
    logic [3:0]        rnib_q, rnib_d;
    logic              wr_en_q, wr_en_d;
    logic [11:0]       wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic w_accept;
    logic w_wr_done;
    logic w_counting;
    logic w_timeout;

    // rx_ready depends only on registered state, never on wr_grant
    assign w_accept  = rx_valid && !wr_en_q;
    assign w_wr_done = wr_en_q && wr_grant;

    always_comb begin
        w_counting = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        if (state_q == S_CHK) w_counting = 1'b1;
`endif
    end

    // Activity in the same cycle (byte or completed write) beats the timeout
    assign w_timeout = w_counting && (idle_q == IDLE_LIMIT) && !w_accept && !w_wr_done;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pix_q     <= 12'd0;
            rnib_q    <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 12'd0;
            wr_data_q <= 12'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            idle_q    <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            xor_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            rnib_q    <= rnib_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            idle_q    <= idle_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_timeout) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (w_accept && (rx_data == SYNC_BYTE)) state_d = S_HI;
                S_HI:    if (w_accept) state_d = S_LO;
                S_LO:    if (w_accept) state_d = S_WR;
                S_WR:    if (w_wr_done) state_d = (pix_q == LAST_PIX) ? S_AFTER_LAST : S_HI;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                S_CHK:   if (w_accept) state_d = (rx_data == xor_q) ? S_END : S_IDLE;
`endif
                S_END:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_d     = pix_q;
        rnib_d    = rnib_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = 1'b0;
        idle_d    = w_counting ? (idle_q + IDLE_W'(1)) : '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        if (w_timeout) begin
            // Pending pixel is dropped; no completion pulse
            err_d   = 1'b1;
            busy_d  = 1'b0;
            wr_en_d = 1'b0;
            idle_d  = '0;
        end else begin
            if (w_accept || w_wr_done) idle_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept && (rx_data == SYNC_BYTE)) begin
                        pix_d  = 12'd0;
                        err_d  = 1'b0;
                        busy_d = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        xor_d  = 8'd0;
`endif
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        rnib_d = rx_data[3:0];
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        xor_d  = xor_q ^ rx_data;
`endif
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        wr_data_d = {rnib_q, rx_data};
                        wr_addr_d = pix_q;
                        wr_en_d   = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        xor_d     = xor_q ^ rx_data;
`endif
                    end
                end
                S_WR: begin
                    if (w_wr_done) begin
                        wr_en_d = 1'b0;
                        if (pix_q != LAST_PIX) pix_d = pix_q + 12'd1;
                    end
                end
`ifdef SPRITE_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept && (rx_data != xor_q)) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
`endif
                S_END: begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rx_ready = !wr_en_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_loader.sv
`default_nettype none
// tb_sprite_loader: frames built from pixel arrays; expected writes and done
// pulses are queued at stimulus time and matched by an independent monitor.
module tb_sprite_loader;

    localparam int         PIX  = 4096;
    localparam int         TMO  = 48;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 3 * PIX + 2;
`else
    localparam int DONE_LAT = 3 * PIX + 1;
`endif

    logic        clk60MHz = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_grant;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         exp_done  = 0;
    int         n_cmp     = 0;
    int         n_err     = 0;
    int         n_writes  = 0;
    int         n_done    = 0;
    int         cyc       = 0;
    int         done_cyc  = 0;
    int         sync_cyc  = 0;
    logic       prev_done = 1'b0;
    logic       hold_low  = 1'b0;
    logic       rand_grant = 1'b0;
    logic [7:0] xor_acc   = 8'h00;

    sprite_loader #(
        .SYNC_BYTE      (SYNC),
        .PIXELS         (PIX),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_grant (wr_grant),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial forever #5 clk60MHz = ~clk60MHz;
    initial forever begin
        @(posedge clk60MHz);
        cyc++;
    end

    initial begin
        wr_grant = 1'b1;
        forever begin
            @(negedge clk60MHz);
            if (hold_low)        wr_grant = 1'b0;
            else if (rand_grant) wr_grant = ($urandom_range(0, 3) != 0);
            else                 wr_grant = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk60MHz);
            #1;
            if (wr_en && wr_grant) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {20'd0, wr_addr}, {20'd0, e.addr});
                    chk("wr_data", {20'd0, wr_data}, {20'd0, e.data});
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                if (exp_done == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1, none expected");
                end else begin
                    exp_done--;
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 200) begin
            @(negedge clk60MHz);
            waited++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_ready_timeout: byte 0x%0h not accepted in 200 cycles", b);
        end
        @(negedge clk60MHz);
        rx_valid = 1'b0;
    endtask

    task automatic idle_gap(input int gapmax);
        if (gapmax > 0 && $urandom_range(0, 7) == 0)
            repeat ($urandom_range(1, gapmax)) @(negedge clk60MHz);
    endtask

    // HI byte carries R in its low nibble; the high nibble is random junk
    function automatic logic [7:0] mk_hi(input logic [11:0] p);
        logic [3:0] junk;
        junk = 4'($urandom_range(0, 15));
        return {junk, p[11:8]};
    endfunction

    task automatic send_pixel(input logic [11:0] p, input int gapmax);
        logic [7:0] hi;
        hi = mk_hi(p);
        xor_acc = xor_acc ^ hi ^ p[7:0];
        idle_gap(gapmax);
        send_byte(hi);
        idle_gap(gapmax);
        send_byte(p[7:0]);
    endtask

    task automatic push_exp(input int idx, input logic [11:0] p);
        exp_q.push_back('{addr: 12'(idx), data: p});
    endtask

    // kind 0: pixel i = i[11:0]; otherwise random pixels
    task automatic send_frame(input int kind, input int gapmax);
        logic [11:0] p;
        xor_acc = 8'h00;
        send_byte(SYNC);
        sync_cyc = cyc;
        for (int i = 0; i < PIX; i++) begin
            p = (kind == 0) ? 12'(i) : 12'($urandom);
            push_exp(i, p);
            send_pixel(p, gapmax);
        end
    endtask

    task automatic finish_frame();
`ifdef SPRITE_LOADER_CHECKSUM_EN
        send_byte(xor_acc);
`endif
    endtask

    task automatic wait_done(input string name);
        int start;
        int waited;
        start  = n_done;
        waited = 0;
        while (n_done == start && waited < 100) begin
            @(negedge clk60MHz);
            waited++;
        end
        #2;
        chk(name, 32'(n_done - start), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_addr"},  {20'd0, wr_addr},  32'd0);
        chk({tag, "_wr_data"},  {20'd0, wr_data},  32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    task automatic pulse_rst(input string tag);
        @(negedge clk60MHz);
        rst = 1'b1;
        @(negedge clk60MHz);
        rst = 1'b0;
        #1;
        check_reset(tag);
    endtask

    initial begin : stimulus
        int          nw;
        int          nd;
        logic [11:0] p;
        logic [11:0] p6;
        logic [7:0]  b;
        logic [7:0]  hi6;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk60MHz);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Smoke: leading junk byte, then one pixel
        @(negedge clk60MHz);
        push_exp(0, 12'hF3C);
        nw = n_writes;
        send_byte(8'h12);
        chk("junk_before_sync_busy", {31'd0, busy}, 32'd0);
        send_byte(SYNC);
        send_byte(8'h0F);
        send_byte(8'h3C);
        repeat (3) @(negedge clk60MHz);
        #2;
        chk("smoke_write_count", 32'(n_writes - nw), 32'd1);
        chk("smoke_busy", {31'd0, busy}, 32'd1);
        chk("smoke_rx_ready", {31'd0, rx_ready}, 32'd1);
        pulse_rst("smoke_rst");

        // Full ramp frame at full rate
        rand_grant = 1'b0;
        exp_done++;
        send_frame(0, 0);
        finish_frame();
        wait_done("ramp_done");
        chk("ramp_done_latency", 32'(done_cyc - sync_cyc), 32'(DONE_LAT));
        chk("ramp_busy_after", {31'd0, busy}, 32'd0);
        nw = n_writes;
        send_byte(8'h00);
        repeat (4) @(negedge clk60MHz);
        #2;
        chk("post_done_byte_ignored", 32'(n_writes - nw), 32'd0);
        chk("post_done_busy", {31'd0, busy}, 32'd0);

        // Random frame, random byte gaps and random grant
        rand_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            send_byte(b);
        end
        chk("garbage_ignored_busy", {31'd0, busy}, 32'd0);
        exp_done++;
        send_frame(1, 3);
        finish_frame();
        wait_done("rand_done");
        rand_grant = 1'b0;

        // Grant stall at pixel 5, then stream stops inside pixel 100
        xor_acc = 8'h00;
        send_byte(SYNC);
        chk("sync_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            p = 12'($urandom);
            push_exp(i, p);
            send_pixel(p, 0);
        end
        p = 12'($urandom);
        push_exp(5, p);
        send_byte(mk_hi(p));
        hold_low = 1'b1;
        send_byte(p[7:0]);
        p6       = 12'($urandom);
        hi6      = mk_hi(p6);
        rx_data  = hi6;
        rx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("stall_wr_en",    {31'd0, wr_en},    32'd1);
            chk("stall_wr_addr",  {20'd0, wr_addr},  32'h005);
            chk("stall_wr_data",  {20'd0, wr_data},  {20'd0, p});
            chk("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
            @(negedge clk60MHz);
        end
        hold_low = 1'b0;
        push_exp(6, p6);
        send_byte(hi6);
        send_byte(p6[7:0]);
        for (int i = 7; i < 100; i++) begin
            p = 12'($urandom);
            push_exp(i, p);
            send_pixel(p, 0);
        end
        nd = n_done;
        send_byte(mk_hi(12'($urandom)));
        repeat (TMO - 1) @(negedge clk60MHz);
        #1;
        chk("timeout_err_before", {31'd0, err}, 32'd0);
        chk("timeout_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk60MHz);
        #1;
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_wr_en", {31'd0, wr_en}, 32'd0);
        repeat (5) @(negedge clk60MHz);
        #2;
        chk("timeout_no_done", 32'(n_done - nd), 32'd0);
        chk("timeout_err_sticky", {31'd0, err}, 32'd1);
        send_byte(SYNC);
        #1;
        chk("resync_err_cleared", {31'd0, err}, 32'd0);
        chk("resync_busy", {31'd0, busy}, 32'd1);

        // Reset with pixel 2000 waiting for its grant
        for (int i = 0; i < 2000; i++) begin
            p = 12'($urandom);
            push_exp(i, p);
            send_pixel(p, 0);
        end
        p = 12'($urandom);
        send_byte(mk_hi(p));
        hold_low = 1'b1;
        send_byte(p[7:0]);
        @(negedge clk60MHz);
        #1;
        chk("rst_pending_wr_en", {31'd0, wr_en}, 32'd1);
        pulse_rst("midframe_rst");
        hold_low = 1'b0;
        nw = n_writes;
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b);
        end
        repeat (4) @(negedge clk60MHz);
        #2;
        chk("post_rst_bytes_ignored", 32'(n_writes - nw), 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_err", {31'd0, err}, 32'd0);

`ifdef SPRITE_LOADER_CHECKSUM_EN
        exp_done++;
        send_frame(1, 0);
        send_byte(xor_acc);
        wait_done("csum_good_done");
        nd = n_done;
        send_frame(1, 0);
        send_byte(xor_acc ^ 8'h01);
        repeat (5) @(negedge clk60MHz);
        #2;
        chk("csum_bad_err", {31'd0, err}, 32'd1);
        chk("csum_bad_busy", {31'd0, busy}, 32'd0);
        chk("csum_bad_no_done", 32'(n_done - nd), 32'd0);
`endif

        repeat (5) @(negedge clk60MHz);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("done_tokens_left", 32'(exp_done), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
